// File: rtl/alu_issue_ctrl.sv
// Issue controller for an RV64 integer/branch ALU. It decodes one op per handshake, holds the ALU
// operands for that op's latency, captures the result and branch decision, and returns them.
module alu_issue_ctrl #(
  parameter int XLEN        = 64,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [1:0]      alu_control,
  output logic [2:0]      alu_select,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_negu,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_taken,
  output logic            out_illegal,
  output logic [1:0]      dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high; the
  // response side keeps every out_* field stable while out_valid is high and out_ready is low.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  localparam int CW = 8;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_in1, r_in2, r_result;
  logic [2:0]        r_sel, r_f3;
  logic [1:0]        r_ctl;
  logic              r_branch, r_taken, r_illegal;

  logic              w_accept, w_ill, w_br, w_taken;
  logic [2:0]        w_sel;
  logic [1:0]        w_ctl;
  logic [CW-1:0]     w_lat_m1;
  logic [XLEN-1:0]   w_in2;

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_state == S_DONE);
  assign alu_in1     = r_in1;
  assign alu_in2     = r_in2;
  assign alu_select  = r_sel;
  assign alu_control = r_ctl;
  assign out_result  = r_result;
  assign out_taken   = r_taken;
  assign out_illegal = r_illegal;
  assign dbg_state   = r_state;

  always_comb begin
    w_ill    = 1'b0;
    w_br     = 1'b0;
    w_sel    = 3'b000;
    w_ctl    = 2'b00;
    w_lat_m1 = '0;
    w_in2    = in_rs2;
    case (in_opcode)
      OPC_OP: begin
        case (in_funct7)
          7'b0000000: begin
            case (in_funct3)
              3'b000:  w_sel = 3'b000;
              3'b001:  w_sel = 3'b011;
              3'b100:  w_sel = 3'b101;
              3'b101:  w_sel = 3'b100;
              3'b110:  w_sel = 3'b110;
              3'b111:  w_sel = 3'b111;
              default: w_ill = 1'b1;
            endcase
          end
          7'b0100000: begin
            w_ctl = 2'b01;
            if (in_funct3 == 3'b101) w_sel = 3'b100;
            else if (in_funct3 != 3'b000) w_ill = 1'b1;
          end
          7'b0000001: begin
            // funct3[2] splits the M extension into multiplier and divider groups.
            w_ctl = in_funct3[1:0];
            if (in_funct3[2]) begin
              w_sel    = 3'b010;
              w_lat_m1 = CW'(DIV_LATENCY - 1);
            end else begin
              w_sel    = 3'b001;
              w_lat_m1 = CW'(MUL_LATENCY - 1);
            end
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_IMM: begin
        w_in2 = in_imm;
        case (in_funct3)
          3'b000:  w_sel = 3'b000;
          3'b100:  w_sel = 3'b101;
          3'b110:  w_sel = 3'b110;
          3'b111:  w_sel = 3'b111;
          3'b001: begin
            w_sel = 3'b011;
            if (in_imm[11:6] != 6'b000000) w_ill = 1'b1;
          end
          3'b101: begin
            w_sel = 3'b100;
            if (in_imm[11:6] == 6'b010000) w_ctl = 2'b01;
            else if (in_imm[11:6] != 6'b000000) w_ill = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_BR: begin
        w_br  = 1'b1;
        w_ctl = 2'b01;
        if (in_funct3[2:1] == 2'b01) w_ill = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // funct3[0] inverts the base condition picked by funct3[2:1].
  always_comb begin
    case (r_f3[2:1])
      2'b10:   w_taken = alu_neg ^ r_f3[0];
      2'b11:   w_taken = alu_negu ^ r_f3[0];
      default: w_taken = alu_zero ^ r_f3[0];
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_ill ? S_DONE : S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_sel     <= 3'b000;
      r_ctl     <= 2'b00;
      r_f3      <= 3'b000;
      r_branch  <= 1'b0;
      r_result  <= '0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_ill) begin
            r_result  <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b1;
          end else if (w_accept) begin
            r_in1    <= in_rs1;
            r_in2    <= w_in2;
            r_sel    <= w_sel;
            r_ctl    <= w_ctl;
            r_cnt    <= w_lat_m1;
            r_branch <= w_br;
            r_f3     <= in_funct3;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_result  <= r_branch ? '0 : alu_out;
            r_taken   <= r_branch && w_taken;
            r_illegal <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
